// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN pixel-stream blocks: default image geometry and
// the streamer state encoding.
package cnn_stream_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned IMG_W     = 28;
  localparam int unsigned IMG_H     = 28;
  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFinish
  } stream_state_e;

endpackage

// File: rtl/pixel_streamer_if.sv
// Pixel stream link: valid/ready handshake carrying one pixel plus frame/line markers.
interface pixel_streamer_if #(
  parameter int unsigned PIX_W = 8
) ();

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_sof,
    output pix_eol,
    output pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_sof,
    input  pix_eol,
    input  pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/frame_ram.sv
// Single-write-port, asynchronous-read pixel store for one frame; contents are not reset.
module frame_ram #(
  parameter int unsigned PIX_W  = cnn_stream_pkg::PIX_W,
  parameter int unsigned DEPTH  = cnn_stream_pkg::FRAME_PIX,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_streamer.sv
// Frame source for the CNN pipeline: host-loaded frame memory streamed out in raster
// order over a valid/ready link with sof/eol/eof markers.
module pixel_streamer
  import cnn_stream_pkg::stream_state_e, cnn_stream_pkg::StIdle, cnn_stream_pkg::StStream,
         cnn_stream_pkg::StFinish;
#(
  parameter int unsigned PIX_W  = cnn_stream_pkg::PIX_W,
  parameter int unsigned IMG_W  = cnn_stream_pkg::IMG_W,
  parameter int unsigned IMG_H  = cnn_stream_pkg::IMG_H,
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  pixel_streamer_if.master   pix
);

  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned ColW   = $clog2(IMG_W + 1);
  localparam int unsigned RowW   = $clog2(IMG_H + 1);
  localparam logic [ColW-1:0] LastCol = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(IMG_H - 1);

  stream_state_e     state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              ram_we;
  logic [PIX_W-1:0]  rd_data;

  // Read address is the next-state address so the pixel lands in data_q with its markers.
  frame_ram #(
    .PIX_W (PIX_W),
    .DEPTH (NumPix),
    .ADDR_W(ADDR_W)
  ) u_frame_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(addr_d),
    .rdata(rd_data)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    ram_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        ram_we = wr_en && (32'(wr_addr) < NumPix);
        if (start) begin
          state_d = StStream;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          sof_d   = 1'b1;
          eol_d   = (IMG_W == 1);
          eof_d   = (NumPix == 1);
        end
      end
      StStream: begin
        if (pix.pix_ready) begin
          sof_d = 1'b0;
          if (eof_q) begin
            state_d = StFinish;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
            if (col_q == LastCol) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            eol_d = (col_d == LastCol);
            eof_d = (col_d == LastCol) && (row_d == LastRow);
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    data_d = (state_d == StStream) ? rd_data : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign busy          = (state_q == StStream);
  assign done          = (state_q == StFinish);
  assign pix.pix_valid = (state_q == StStream);
  assign pix.pix_data  = data_q;
  assign pix.pix_sof   = sof_q;
  assign pix.pix_eol   = eol_q;
  assign pix.pix_eof   = eof_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: scoreboarded 28x28 frames plus a 4x3 instance.
module tb_pixel_streamer;

  typedef logic [10:0] beat_t;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       s_wr_en;
  logic       s_start;
  logic       s_busy;
  logic       s_done;
  bit         rnd_ready;

  int unsigned total;
  int unsigned passed;
  int unsigned done_cnt;
  logic [7:0]  model [784];
  beat_t       exp_q [$];
  beat_t       cur;
  beat_t       prev;
  beat_t       exp_b;
  bit          prev_stall;

  pixel_streamer_if #(.PIX_W(8)) pix ();
  pixel_streamer_if #(.PIX_W(8)) ps ();

  pixel_streamer #(
    .PIX_W (8),
    .IMG_W (28),
    .IMG_H (28),
    .ADDR_W(10)
  ) dut (
    .clock  (clk),
    .reset  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .pix    (pix)
  );

  pixel_streamer #(
    .PIX_W (8),
    .IMG_W (4),
    .IMG_H (3),
    .ADDR_W(4)
  ) dut_s (
    .clock  (clk),
    .reset  (rst_n),
    .wr_en  (s_wr_en),
    .wr_addr(wr_addr[3:0]),
    .wr_data(wr_data),
    .start  (s_start),
    .busy   (s_busy),
    .done   (s_done),
    .pix    (ps)
  );

  assign ps.pix_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: ready is re-drawn just after every active edge.
  initial begin
    pix.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor: pop one expectation per accepted beat, check holds during stalls.
  always @(negedge clk) begin
    cur = {pix.pix_data, pix.pix_sof, pix.pix_eol, pix.pix_eof};
    if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev));
    if (pix.pix_valid && pix.pix_ready) begin
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("beat", 32'(cur), 32'(exp_b));
    end
    if (done) done_cnt++;
    prev_stall = pix.pix_valid && !pix.pix_ready;
    prev       = cur;
  end

  task automatic push_frame();
    for (int k = 0; k < 784; k++) begin
      exp_q.push_back({model[k], k == 0, (k % 28) == 27, k == 783});
    end
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < 784) model[a] = d;
  endtask

  // One frame; optional mid-stream write to addr 500 and start pulses at given cycles.
  task automatic run_frame(input bit rr, input int wr_at, input int st1, input int st2,
                           input int exp_cycles);
    int n;
    int unsigned dc;
    dc = done_cnt;
    push_frame();
    rnd_ready = rr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", 32'(pix.pix_valid), 1);
    chk("first_busy", 32'(busy), 1);
    chk("first_beat", 32'({pix.pix_data, pix.pix_sof}), 32'({model[0], 1'b1}));
    n = 0;
    while (!done && n < 8000) begin
      wr_en   = (n == wr_at);
      wr_addr = 10'd500;
      wr_data = 8'hAA;
      start   = (n == st1) || (n == st2);
      tick();
      n++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("done_seen", 32'(done), 1);
    chk("done_busy_low", 32'(busy), 0);
    if (exp_cycles > 0) chk("frame_cycles", 32'(n), 32'(exp_cycles));
    tick();
    chk("sb_drained", exp_q.size(), 0);
    chk("done_pulse_len", 32'(done), 0);
    chk("idle_valid", 32'(pix.pix_valid), 0);
    chk("done_count", done_cnt - dc, 1);
    rnd_ready = 1'b0;
  endtask

  initial begin
    int          n;
    int          first_n;
    int unsigned dc;
    logic [7:0]  sd;
    total = 0; passed = 0; done_cnt = 0;
    rnd_ready = 1'b0; prev_stall = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    s_wr_en = 1'b0; s_start = 1'b0;
    #1;
    chk("rst_valid", 32'(pix.pix_valid), 0);
    chk("rst_busy_done", 32'({busy, done}), 0);
    chk("rst_data_markers", 32'({pix.pix_data, pix.pix_sof, pix.pix_eol, pix.pix_eof}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Ramp frame, then an out-of-range write that must not disturb anything.
    for (int i = 0; i < 784; i++) host_write(i, 8'(i));
    host_write(800, 8'h55);
    run_frame(1'b0, -1, -1, -1, 784);

    // Random backpressure.
    run_frame(1'b1, -1, -1, -1, 0);

    // Write to 500 while streaming is ignored; starts at beats 10 and 783 are ignored.
    run_frame(1'b0, 200, 10, 783, 784);
    tick(); tick();
    chk("no_restart", 32'({busy, pix.pix_valid}), 0);

    // Idle write takes effect on the next frame.
    host_write(500, 8'hAA);
    run_frame(1'b0, -1, -1, -1, 784);

    // Start held high: two frames separated by FINISH and IDLE cycles.
    push_frame();
    push_frame();
    dc = done_cnt;
    first_n = 0;
    n = 0;
    start = 1'b1;
    while (n < 4000) begin
      tick();
      n++;
      if (done && first_n == 0) first_n = n;
      else if (done) break;
    end
    start = 1'b0;
    chk("held_first_done", 32'(first_n), 785);
    chk("held_second_done", 32'(n), 1571);
    tick();
    chk("held_done_count", done_cnt - dc, 2);
    chk("held_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of beat 300.
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_busy", 32'({pix.pix_valid, busy, done}), 0);
    chk("arst_data_markers", 32'({pix.pix_data, pix.pix_sof, pix.pix_eol, pix.pix_eof}), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_stays_idle", 32'({pix.pix_valid, busy}), 0);
    run_frame(1'b0, -1, -1, -1, 784);

    // 4x3 instance.
    for (int i = 0; i < 12; i++) begin
      s_wr_en = 1'b1;
      wr_addr = 10'(i);
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    s_wr_en = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sd = 8'hC0 + 8'(k);
      chk("small_beat", 32'({ps.pix_valid, ps.pix_data, ps.pix_sof, ps.pix_eol, ps.pix_eof}),
          32'({1'b1, sd, k == 0, (k % 4) == 3, k == 11}));
      tick();
    end
    chk("small_done", 32'({s_done, s_busy, ps.pix_valid}), 32'(3'b100));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
Source end of the CNN pixel stream. It holds one IMG_W x IMG_H frame of 8-bit pixels, written by the host through a simple write port. On start, it emits the frame in raster order, one pixel per accepted beat, into the downstream line-buffer/window chain. Valid/ready handshake with frame and line markers; when the consumer ties pix_ready high, the stream runs at one pixel per clock with no bubbles.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 28, pixels per row
IMG_H, 28, rows per frame
ADDR_W, 10, frame address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
wr_en  in  1  host write strobe
wr_addr  in  ADDR_W  linear pixel address, row*IMG_W+col
wr_data  in  PIX_W  pixel to store
start  in  1  begin streaming stored frame (level sampled per cycle)
busy  out  1  high from the cycle after an accepted start until the cycle done pulses
done  out  1  one-cycle pulse after the last pixel is accepted
pix_valid  out  1  pix_data/markers valid
pix_ready  in  1  consumer accepts this cycle
pix_data  out  PIX_W  current pixel
pix_sof  out  1  current pixel is row 0, col 0
pix_eol  out  1  current pixel is col IMG_W-1
pix_eof  out  1  current pixel is last of frame

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, pix_valid, pix_sof, pix_eol, pix_eof = 0; pix_data = 0; row/col counters = 0. Frame memory contents are not reset.
- Reset mid-stream aborts immediately; the next start after release streams from pixel 0.
- FSM states: IDLE, STREAM, FINISH.
- IDLE: wr_en=1 with wr_addr < IMG_W*IMG_H writes wr_data at the clock edge; out-of-range addresses are dropped.
- IDLE -> STREAM: on start=1. The next cycle has pix_valid=1, pix_data=mem[0], pix_sof=1, busy=1.
- STREAM: a beat transfers when pix_valid & pix_ready.
  - While not transferred, pix_data and all markers hold stable.
  - On a transfer of a non-last pixel, the next pixel is presented the following cycle, so back-to-back beats have no gap.
  - col wraps IMG_W-1 -> 0 with row+1.
  - Markers are registered with the data: pix_eol when col==IMG_W-1; pix_eof when row==IMG_H-1 and col==IMG_W-1. pix_sof is only on the first beat.
- STREAM -> FINISH: on transfer of the eof pixel. In FINISH, pix_valid=0, done=1, busy=0 for one cycle, then unconditionally IDLE.
- wr_en is ignored while in STREAM or FINISH; the streamed frame is immutable.
- start is ignored in STREAM and FINISH. A start held high through FINISH restarts from IDLE on the following cycle, with no overlap.
- Latency: start to first valid pixel is 1 cycle. With pix_ready tied to 1, a frame is IMG_W*IMG_H beats, and done comes 1 cycle after the eof beat.
- Arithmetic: linear read address is kept as an ADDR_W counter alongside row/col; no multiply.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - IMG_W, IMG_H and PIX_W defaults, shared with the line-buffer/shift-register blocks;
  - the FRAME_PIX = IMG_W*IMG_H constant;
  - the streamer state enum {IDLE, STREAM, FINISH}.
- One sub-module, frame_ram: single-write port, asynchronous-read pixel array of FRAME_PIX x PIX_W, no reset. The FSM, counters and output registers stay in pixel_streamer.

Test Plan:
- Ramp frame: write mem[i]=i[7:0] for i=0..783, pulse start, pix_ready=1 -> 784 consecutive beats with data 0,1,...,255,0,...,15. Expect sof on beat 0 only, eol on beats 27,55,...,783, eof on beat 783 only, done one cycle later, busy low after.
- Backpressure: random pix_ready (~50%) on the ramp frame -> identical 784-value sequence, data/markers stable whenever valid&!ready, no dropped or duplicated beats.
- Writes during stream: wr_en to addr 500 with 0xAA mid-frame -> beat 500 still shows its original value; after done, a write followed by a restart shows 0xAA at beat 500. Out-of-range write to addr 800 has no effect.
- Start during busy: start pulsed at beats 10 and 783 -> single frame, exactly one done. start held high continuously -> frames back to back, each separated by the FINISH and IDLE cycles, done once per frame.
- Async reset mid-frame at beat 300 -> all outputs 0 without waiting for a clock edge. After release, start gives beat 0 = mem[0] with sof=1, and memory contents are retained.
- Parameter check IMG_W=4, IMG_H=3 -> 12 beats, eol on beats 3,7,11, eof on beat 11.
